// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and types for the modular-reduction datapath
//
// Purpose: operand widths, FSM state encoding and bit-counter sizing shared by
//          mod_reduce_32by16 and mod_csub.
package rsa_pkg;

    // Operand / modulus width; the product is twice as wide.
    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;

    // Counter must be able to hold PW itself, hence the extra bit.
    localparam int CNT_W = $clog2(PW) + 1;

    // Counter value on the final shift/subtract step.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_csub.sv
// rtl/mod_csub.sv - conditional subtract step of restoring modular reduction
//
// Purpose: given a partial remainder t (< 2n, WIDTH+1 bits) and modulus n,
//          returns t - n when t >= n, else t. The result always fits WIDTH bits.
// Ports:
//   t  in   WIDTH+1  shifted partial remainder
//   n  in   WIDTH    modulus
//   r  out  WIDTH    reduced remainder (< n)
module mod_csub
    import rsa_pkg::*;
(
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r
);

    logic             ge;
    logic [WIDTH-1:0] diff;

    assign ge = (t >= {1'b0, n});

    // The true difference is < n when ge holds, so the low WIDTH bits of the
    // modular subtraction are exact and the carry-out can be dropped.
    assign diff = t[WIDTH-1:0] - n;

    assign r = ge ? diff : t[WIDTH-1:0];

endmodule

// File: rtl/mod_reduce_32by16.sv
// rtl/mod_reduce_32by16.sv - sequential 32-bit mod 16-bit remainder with valid/ready
//
// Purpose: computes r_out = p_in mod n_in by restoring shift/compare/subtract,
//          one product bit per clock (2*WIDTH clocks per operation). A zero
//          modulus completes immediately with err=1 and r_out=0.
// Ports:
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        synchronous reset, active-high
//   p_in       in   2*WIDTH  product to reduce
//   n_in       in   WIDTH    modulus
//   in_valid   in   1        p_in/n_in valid
//   in_ready   out  1        block can accept (high only in IDLE)
//   r_out      out  WIDTH    remainder, held until the next result
//   err        out  1        modulus was zero (qualified by out_valid)
//   out_valid  out  1        r_out/err valid
//   out_ready  in   1        consumer accepts result
module mod_reduce_32by16
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    p_in,
    input  logic [WIDTH-1:0] n_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] r_out,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [PW-1:0]    p_sh;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_next;

    // r_reg < n_reg always holds, so the top bit of the architectural
    // WIDTH+1-bit remainder is never set and is not stored.
    assign t = {r_reg, p_sh[PW-1]};

    mod_csub u_csub (
        .t (t),
        .n (n_reg),
        .r (r_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r_out     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            p_sh      <= '0;
            n_reg     <= '0;
            r_reg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        p_sh     <= p_in;
                        n_reg    <= n_in;
                        r_reg    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (n_in == '0) begin
                            // Division by zero: report immediately.
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            r_out     <= '0;
                            err       <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            err   <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    p_sh  <= {p_sh[PW-2:0], 1'b0};
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Present the final step's remainder on the same edge
                        // that raises out_valid.
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        r_out     <= r_next;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_32by16.sv
// tb/tb_mod_reduce_32by16.sv - self-checking bench for mod_reduce_32by16
module tb_mod_reduce_32by16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] p_in = '0;
    logic [15:0] n_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] r_out;
    logic        err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_reduce_32by16 dut (
        .clk       (clk),
        .rst       (rst),
        .p_in      (p_in),
        .n_in      (n_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_out     (r_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    typedef struct {
        logic [31:0] p;
        logic [15:0] n;
        longint      acc;
    } op_t;

    op_t         q[$];
    logic        prev_ov = 1'b0;
    logic [15:0] last_r  = '0;
    logic        armed   = 1'b0;

    function automatic logic [15:0] ref_rem(input logic [31:0] p, input logic [15:0] n);
        logic [31:0] nn;
        nn = {16'd0, n};
        if (n == 16'd0) return 16'd0;
        return 16'(p % nn);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            last_r  = '0;
            prev_ov = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            chk("m_in_ready", in_ready, q.size() == 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("m_spurious_valid", out_valid, 1'b0);
                end else begin
                    chk("m_r_out", r_out, ref_rem(q[0].p, q[0].n));
                    chk("m_err", err, q[0].n == 16'd0);
                    // Zero modulus answers on the accept edge; otherwise 32 edges later.
                    if (!prev_ov)
                        chk("m_latency", 32'(cyc - q[0].acc - 1), (q[0].n == 16'd0) ? 32'd0 : 32'd32);
                    if (out_ready) begin
                        last_r = ref_rem(q[0].p, q[0].n);
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("m_r_hold", r_out, last_r);
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) q.push_back('{p: p_in, n: n_in, acc: cyc});
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [31:0] p, input logic [15:0] n, input int hold,
                         input bit stray, output logic [15:0] r, output logic e,
                         output int lat);
        int k;
        p_in = p; n_in = n; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 200) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 100) chk("result_timeout", 0, 1);
        r = r_out; e = err;
        for (int i = 0; i < hold; i++) begin
            if (stray) begin
                in_valid = 1'b1; p_in = $urandom; n_in = 16'd3;
            end
            @(posedge clk); #1;
            if (stray) begin
                chk("bp_in_ready", in_ready, 1'b0);
                chk("bp_r_stable", r_out, r);
                chk("bp_valid", out_valid, 1'b1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] r;
    logic        e;
    int          lat;
    logic [15:0] a_op, b_op, n_rand;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_r_out", r_out, 16'h0000);
        chk("rst_err", err, 1'b0);

        do_op(32'h0000_0064, 16'h0007, 0, 0, r, e, lat);
        chk("t1_r", r, 16'h0002); chk("t1_err", e, 1'b0); chk("t1_lat", lat, 32);
        chk("t1_idle_ready", in_ready, 1'b1); chk("t1_idle_valid", out_valid, 1'b0);

        do_op(32'hFFFE_0001, 16'hFFF1, 1, 0, r, e, lat);
        chk("t2a_r", r, 16'h00C4);
        do_op(32'h0000_0005, 16'h0009, 0, 0, r, e, lat);
        chk("t2b_r", r, 16'h0005);

        do_op(32'hDEAD_BEEF, 16'h0000, 0, 0, r, e, lat);
        chk("t3_zero_r", r, 16'h0000); chk("t3_zero_err", e, 1'b1); chk("t3_zero_lat", lat, 0);
        do_op(32'hDEAD_BEEF, 16'h0001, 0, 0, r, e, lat);
        chk("t3_one_r", r, 16'h0000); chk("t3_one_err", e, 1'b0);

        do_op(32'hFFFF_FFFF, 16'hFFFF, 0, 0, r, e, lat);
        chk("max_ffff_r", r, 16'h0000);
        do_op(32'hFFFF_FFFF, 16'h8000, 0, 0, r, e, lat);
        chk("max_8000_r", r, 16'h7FFF);
        do_op(32'h0000_0000, 16'h1234, 0, 0, r, e, lat);
        chk("p_zero_r", r, 16'h0000);

        // Backpressure with a stray request every held cycle.
        do_op(32'h0001_0000, 16'h00FF, 10, 1, r, e, lat);
        chk("t4_r", r, 16'h0001); chk("t4_err", e, 1'b0);
        chk("t4_in_ready", in_ready, 1'b1); chk("t4_out_valid", out_valid, 1'b0);

        // Reset in the middle of a run.
        p_in = 32'hFFFE_0001; n_in = 16'hFFF1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_r_out", r_out, 16'h0000);
        chk("t5_in_ready", in_ready, 1'b1);
        do_op(32'h0000_0064, 16'h0007, 0, 0, r, e, lat);
        chk("t5_after_r", r, 16'h0002); chk("t5_after_lat", lat, 32);

        // Multiplier-fed stream, checked by the monitor model.
        a_op = 16'h1234; b_op = 16'hFEDC;
        for (int i = 0; i < 200; i++) begin
            n_rand = 16'($urandom);
            if (i % 25 == 7) n_rand = 16'h0000;
            if (i % 25 == 13) n_rand = 16'h0001;
            do_op(32'(a_op) * 32'(b_op), n_rand, $urandom_range(0, 3), 0, r, e, lat);
            chk("t6_r", r, ref_rem(32'(a_op) * 32'(b_op), n_rand));
            a_op = a_op + 16'd1;
            b_op = b_op + 16'd3;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("end_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
